ir_receiver_nec: RTL and testbench
==================================

Name: ir_receiver_nec

Overview:
- NEC IR frame decoder for the DE1-SoC IR receiver path; the receive-side counterpart of the board's NEC transmitter.
- Samples the demodulated IR receiver output (carrier already stripped) and times marks and spaces with a 50 MHz counter.
- Reassembles the 32-bit frame (address, ~address, command, ~command, LSB first) and checks the inverted bytes.
- Presents the decoded address and command with a one-cycle valid pulse.

Parameters:
- LEAD_MARK_MIN, 400000, minimum leader mark (8.0 ms)
- LEAD_MARK_MAX, 500000, maximum leader mark (10.0 ms)
- LEAD_SPACE_MIN, 200000, minimum leader space (4.0 ms)
- LEAD_SPACE_MAX, 250000, maximum leader space (5.0 ms)
- BIT_MARK_MIN, 15000, minimum bit/stop mark and minimum bit space (300 us)
- BIT_MARK_MAX, 40000, maximum bit/stop mark (800 us)
- BIT_SPACE_THRESH, 56250, space below this decodes as 0, at or above as 1 (1.125 ms)
- BIT_SPACE_MAX, 125000, maximum bit space (2.5 ms)

Ports:
- iCLK_50  in  1  50 MHz clock
- iRST_n  in  1  asynchronous active-low reset
- iIRDA  in  1  demodulated IR input; active-low (0 = carrier burst/mark), idle high; asynchronous to iCLK_50
- oADDRESS  out  8  last valid address
- oCOMMAND  out  8  last valid command
- oDATA_READY  out  1  one-cycle pulse when a valid frame has been latched
- oERR  out  1  one-cycle pulse on a timing or checksum error
- oREPEAT  out  1  one-cycle pulse on a repeat code; tied 0 unless REPEAT_CODE_EN is defined
- oRX_BUSY  out  1  high from leader start until return to IDLE

Behaviour:
- Reset: all outputs 0; synchroniser flops reset to 1 (idle line); state IDLE; counter, bit count and shift register cleared. Reset mid-frame aborts the frame with no error pulse.
- Input: 2-flop synchroniser, then a previous-sample register. A fall is prev=1 and cur=0; a rise is prev=0 and cur=1.
- Timing counter: 20 bits, clears on every edge, otherwise increments and saturates at 2^20-1.
- IDLE: on fall, go to LEAD_MARK, set busy, clear the counter.
- LEAD_MARK: on rise, go to LEAD_SPACE if the count is in [LEAD_MARK_MIN, LEAD_MARK_MAX], otherwise error. If the count exceeds LEAD_MARK_MAX while the line is still low, error immediately.
- LEAD_SPACE: on fall, go to BIT_MARK with bit count 0 if the count is in [LEAD_SPACE_MIN, LEAD_SPACE_MAX]; see Optional Feature for the repeat window; otherwise error. Count above LEAD_SPACE_MAX is an error.
- BIT_MARK: on rise, go to BIT_SPACE if the count is in [BIT_MARK_MIN, BIT_MARK_MAX], otherwise error. Exceeding the max is an error.
- BIT_SPACE: on fall:
  - Count below BIT_MARK_MIN is an error.
  - Count below BIT_SPACE_THRESH decodes as 0; otherwise 1.
  - Shift right into bit 31, so after 32 bits: [7:0]=addr, [15:8]=~addr, [23:16]=cmd, [31:24]=~cmd.
  - Increment bit count; after bit 31 go to STOP_MARK, else BIT_MARK.
  - Count above BIT_SPACE_MAX is an error.
- STOP_MARK: on rise with a valid mark width:
  - If [15:8]==~[7:0] and [31:24]==~[23:16]: update oADDRESS/oCOMMAND and pulse oDATA_READY in the same cycle.
  - Else pulse oERR.
  - Either way go to IDLE.
- Error action: pulse oERR for one cycle, go to IDLE, clear busy. oADDRESS/oCOMMAND keep their previous values.
- oDATA_READY, oERR and oREPEAT are mutually exclusive and never asserted in consecutive cycles for one frame.
- Latency: outputs update 3 iCLK_50 cycles after the stop-mark rise on iIRDA (2 sync + 1 register).
- Line held low after reset produces a false leader that times out with oERR; this is accepted behaviour.

Optional Feature:
- Macro REPEAT_CODE_EN.
- When defined: in LEAD_SPACE, a fall with count in [87500, 137500] (1.75–2.75 ms) goes to STOP_MARK with a repeat flag. A valid stop mark then pulses oREPEAT, leaves oADDRESS/oCOMMAND unchanged and skips the checksum.
- When undefined: that window is an error, and oREPEAT is constant 0.

Decomposition:
- Package ir_nec_pkg holds:
  - the state encoding (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK);
  - nominal NEC durations in 50 MHz ticks, shared with the transmitter (9 ms, 4.5 ms, 2.25 ms, 1.125 ms, 562.5 us);
  - the default tolerance windows;
  - the counter width (20).
- Sub-module ir_rx_sync_edge: 2-flop synchroniser plus previous-sample register, outputting level, rise and fall.

Test Plan:
- Valid NEC frame addr 0x5A, cmd 0x3C at nominal timing -> exactly one oDATA_READY pulse, oADDRESS=0x5A, oCOMMAND=0x3C, oERR never high, busy drops in the same cycle.
- Same frame with ~cmd sent as 0xC4 -> one oERR pulse, no oDATA_READY, oADDRESS/oCOMMAND keep the previous 0x5A/0x3C.
- Leader mark 6 ms -> oERR on the rise, return to IDLE; an immediately following valid frame (addr 0x01, cmd 0xFE) decodes correctly.
- iIRDA held low 20 ms -> oERR about 10 ms after the fall, busy low; no further pulses until the line returns high and a new frame starts.
- iRST_n asserted during bit 10, then released -> all outputs 0 with no oERR; the next full frame addr 0xA5, cmd 0x0F decodes.
- Repeat code (9 ms mark, 2.25 ms space, 562 us mark) after a valid frame -> with REPEAT_CODE_EN: one oREPEAT pulse, address/command unchanged; without it: one oERR pulse.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// Shared NEC IR definitions: receiver state encoding, nominal durations in
// 50 MHz ticks, default receiver tolerance windows and counter width.
package ir_nec_pkg;

    localparam int unsigned CNT_W = 20;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } state_t;

    // Nominal NEC durations at 50 MHz, shared with the transmitter
    localparam int unsigned T_LEAD_MARK   = 450000;  // 9 ms
    localparam int unsigned T_LEAD_SPACE  = 225000;  // 4.5 ms
    localparam int unsigned T_REPEAT_SPACE = 112500; // 2.25 ms
    localparam int unsigned T_BIT_ONE_GAP = 56250;   // 1.125 ms
    localparam int unsigned T_BIT_MARK    = 28125;   // 562.5 us

    localparam cnt_t LEAD_MARK_MIN_DEF    = 20'd400000;
    localparam cnt_t LEAD_MARK_MAX_DEF    = 20'd500000;
    localparam cnt_t LEAD_SPACE_MIN_DEF   = 20'd200000;
    localparam cnt_t LEAD_SPACE_MAX_DEF   = 20'd250000;
    localparam cnt_t BIT_MARK_MIN_DEF     = 20'd15000;
    localparam cnt_t BIT_MARK_MAX_DEF     = 20'd40000;
    localparam cnt_t BIT_SPACE_THRESH_DEF = 20'd56250;
    localparam cnt_t BIT_SPACE_MAX_DEF    = 20'd125000;
    localparam cnt_t REPEAT_SPACE_MIN_DEF = 20'd87500;
    localparam cnt_t REPEAT_SPACE_MAX_DEF = 20'd137500;

    function automatic logic in_window(input cnt_t c, input cnt_t lo, input cnt_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/ir_rx_sync_edge.sv
// Two-flop synchroniser for the asynchronous IR line plus a previous-sample
// register; flops reset to the idle-high level so reset never fakes an edge.
module ir_rx_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = ~prev_q & sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ir_receiver_nec.sv
// NEC IR frame decoder: times marks/spaces on the demodulated line and checks
// the inverted bytes. Repeat-code decoding is enabled by REPEAT_CODE_EN.
module ir_receiver_nec
    import ir_nec_pkg::*;
#(
`ifdef REPEAT_CODE_EN
    parameter cnt_t REPEAT_SPACE_MIN = REPEAT_SPACE_MIN_DEF,
    parameter cnt_t REPEAT_SPACE_MAX = REPEAT_SPACE_MAX_DEF,
`endif
    parameter cnt_t LEAD_MARK_MIN    = LEAD_MARK_MIN_DEF,
    parameter cnt_t LEAD_MARK_MAX    = LEAD_MARK_MAX_DEF,
    parameter cnt_t LEAD_SPACE_MIN   = LEAD_SPACE_MIN_DEF,
    parameter cnt_t LEAD_SPACE_MAX   = LEAD_SPACE_MAX_DEF,
    parameter cnt_t BIT_MARK_MIN     = BIT_MARK_MIN_DEF,
    parameter cnt_t BIT_MARK_MAX     = BIT_MARK_MAX_DEF,
    parameter cnt_t BIT_SPACE_THRESH = BIT_SPACE_THRESH_DEF,
    parameter cnt_t BIT_SPACE_MAX    = BIT_SPACE_MAX_DEF
) (
    input  logic       iCLK_50,
    input  logic       iRST_n,
    input  logic       iIRDA,
    output logic [7:0] oADDRESS,
    output logic [7:0] oCOMMAND,
    output logic       oDATA_READY,
    output logic       oERR,
    output logic       oREPEAT,
    output logic       oRX_BUSY
);

    state_t      state_q;
    state_t      state_d;
    cnt_t        cnt_q;
    logic [4:0]  bit_cnt_q;
    logic [31:0] shift_q;
    logic        level;
    logic        rise;
    logic        fall;
    logic        timing_err;
    logic        stop_ok;
    logic        shift_en;
    logic        bit_val;
    logic        frame_ok;
    logic        data_ready_d;
    logic        err_d;
`ifdef REPEAT_CODE_EN
    logic        rpt_q;
    logic        repeat_q;
    logic        repeat_d;
`endif

    ir_rx_sync_edge u_sync (
        .clk   (iCLK_50),
        .rst_n (iRST_n),
        .din   (iIRDA),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Each timed state waits for its closing edge; an over-long phase aborts
    // without waiting for that edge.
    always_comb begin
        state_d    = state_q;
        timing_err = 1'b0;
        stop_ok    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) state_d = LEAD_MARK;
            end
            LEAD_MARK: begin
                if (rise) begin
                    if (in_window(cnt_q, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_d = LEAD_SPACE;
                    else timing_err = 1'b1;
                end else if (!level && cnt_q > LEAD_MARK_MAX) begin
                    timing_err = 1'b1;
                end
            end
            LEAD_SPACE: begin
                if (fall) begin
                    if (in_window(cnt_q, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) state_d = BIT_MARK;
`ifdef REPEAT_CODE_EN
                    else if (in_window(cnt_q, REPEAT_SPACE_MIN, REPEAT_SPACE_MAX)) state_d = STOP_MARK;
`endif
                    else timing_err = 1'b1;
                end else if (level && cnt_q > LEAD_SPACE_MAX) begin
                    timing_err = 1'b1;
                end
            end
            BIT_MARK: begin
                if (rise) begin
                    if (in_window(cnt_q, BIT_MARK_MIN, BIT_MARK_MAX)) state_d = BIT_SPACE;
                    else timing_err = 1'b1;
                end else if (!level && cnt_q > BIT_MARK_MAX) begin
                    timing_err = 1'b1;
                end
            end
            BIT_SPACE: begin
                if (fall) begin
                    if (cnt_q < BIT_MARK_MIN)     timing_err = 1'b1;
                    else if (bit_cnt_q == 5'd31) state_d = STOP_MARK;
                    else                         state_d = BIT_MARK;
                end else if (level && cnt_q > BIT_SPACE_MAX) begin
                    timing_err = 1'b1;
                end
            end
            STOP_MARK: begin
                if (rise) begin
                    if (in_window(cnt_q, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                        stop_ok = 1'b1;
                        state_d = IDLE;
                    end else begin
                        timing_err = 1'b1;
                    end
                end else if (!level && cnt_q > BIT_MARK_MAX) begin
                    timing_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timing_err) state_d = IDLE;
    end

    always_comb begin
        shift_en = (state_q == BIT_SPACE) && fall && !timing_err;
        bit_val  = (cnt_q >= BIT_SPACE_THRESH);
        frame_ok = (shift_q[15:8] == ~shift_q[7:0]) && (shift_q[31:24] == ~shift_q[23:16]);
`ifdef REPEAT_CODE_EN
        repeat_d     = stop_ok && rpt_q;
        data_ready_d = stop_ok && !rpt_q && frame_ok;
        err_d        = timing_err || (stop_ok && !rpt_q && !frame_ok);
`else
        data_ready_d = stop_ok && frame_ok;
        err_d        = timing_err || (stop_ok && !frame_ok);
`endif
    end

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            if (rise || fall)      cnt_q <= '0;
            else if (cnt_q != '1) cnt_q <= cnt_q + cnt_t'(1);
            if (state_q == LEAD_SPACE && state_d == BIT_MARK) bit_cnt_q <= '0;
            else if (shift_en)                                bit_cnt_q <= bit_cnt_q + 5'd1;
            if (shift_en) shift_q <= {bit_val, shift_q[31:1]};
        end
    end

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            oADDRESS    <= '0;
            oCOMMAND    <= '0;
            oDATA_READY <= 1'b0;
            oERR        <= 1'b0;
        end else begin
            oDATA_READY <= data_ready_d;
            oERR        <= err_d;
            if (data_ready_d) begin
                oADDRESS <= shift_q[7:0];
                oCOMMAND <= shift_q[23:16];
            end
        end
    end

`ifdef REPEAT_CODE_EN
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            rpt_q    <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
            if (state_q == LEAD_SPACE && state_d == STOP_MARK) rpt_q <= 1'b1;
            else if (state_d == IDLE)                          rpt_q <= 1'b0;
        end
    end

    assign oREPEAT = repeat_q;
`else
    assign oREPEAT = 1'b0;
`endif

    assign oRX_BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_ir_receiver_nec.sv
// Directed bench for ir_receiver_nec using time-scaled tolerance windows
// (562.5 us = 20 clocks); honours REPEAT_CODE_EN like the design.
module tb_ir_receiver_nec;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       irda = 1'b1;
    logic [7:0] address;
    logic [7:0] command;
    logic       data_ready;
    logic       err;
    logic       rpt;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int dr_cnt = 0;
    int err_cnt = 0;
    int rep_cnt = 0;
    int excl_cnt = 0;
    int dr_busy_cnt = 0;

    always #5 clk = ~clk;

    ir_receiver_nec #(
`ifdef REPEAT_CODE_EN
        .REPEAT_SPACE_MIN (20'd62),
        .REPEAT_SPACE_MAX (20'd98),
`endif
        .LEAD_MARK_MIN    (20'd284),
        .LEAD_MARK_MAX    (20'd356),
        .LEAD_SPACE_MIN   (20'd142),
        .LEAD_SPACE_MAX   (20'd178),
        .BIT_MARK_MIN     (20'd11),
        .BIT_MARK_MAX     (20'd28),
        .BIT_SPACE_THRESH (20'd40),
        .BIT_SPACE_MAX    (20'd89)
    ) dut (
        .iCLK_50     (clk),
        .iRST_n      (rst_n),
        .iIRDA       (irda),
        .oADDRESS    (address),
        .oCOMMAND    (command),
        .oDATA_READY (data_ready),
        .oERR        (err),
        .oREPEAT     (rpt),
        .oRX_BUSY    (busy)
    );

    always @(negedge clk) begin
        if (data_ready) dr_cnt++;
        if (err) err_cnt++;
        if (rpt) rep_cnt++;
        if (int'(data_ready) + int'(err) + int'(rpt) > 1) excl_cnt++;
        if (data_ready && busy) dr_busy_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        irda = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_leader();
        hold(1'b0, 320);
        hold(1'b1, 160);
    endtask

    task automatic send_bit(input logic b);
        hold(1'b0, 20);
        hold(1'b1, b ? 60 : 20);
    endtask

    task automatic send_stop();
        hold(1'b0, 20);
        irda = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] nc);
        logic [31:0] word;
        word = {nc, c, ~a, a};
        send_leader();
        for (int i = 0; i < 32; i++) send_bit(word[i]);
        send_stop();
    endtask

    initial begin
        int d0, e0, r0;
        int err_at;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_addr", 32'(address), 32'h0);
        check("rst_cmd", 32'(command), 32'h0);
        check("rst_dr", 32'(data_ready), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rep", 32'(rpt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Valid frame 5A/3C, with 3-cycle output latency after stop-mark rise
        d0 = dr_cnt; e0 = err_cnt;
        send_frame(8'h5A, 8'h3C, 8'hC3);
        repeat (2) @(negedge clk);
        check("f1_dr_early", 32'(data_ready), 32'h0);
        @(negedge clk);
        check("f1_dr_pulse", 32'(data_ready), 32'h1);
        check("f1_busy_drop", 32'(busy), 32'h0);
        check("f1_addr_now", 32'(address), 32'h5A);
        repeat (10) @(negedge clk);
        check("f1_dr_count", 32'(dr_cnt - d0), 32'h1);
        check("f1_err_count", 32'(err_cnt - e0), 32'h0);
        check("f1_addr", 32'(address), 32'h5A);
        check("f1_cmd", 32'(command), 32'h3C);

        // Bad inverted command
        d0 = dr_cnt; e0 = err_cnt;
        send_frame(8'h5A, 8'h3C, 8'hC4);
        repeat (3) @(negedge clk);
        check("bad_err_pulse", 32'(err), 32'h1);
        repeat (10) @(negedge clk);
        check("bad_err_count", 32'(err_cnt - e0), 32'h1);
        check("bad_dr_count", 32'(dr_cnt - d0), 32'h0);
        check("bad_addr_kept", 32'(address), 32'h5A);
        check("bad_cmd_kept", 32'(command), 32'h3C);

        // Short (6 ms) leader, then an immediate valid frame 01/FE
        d0 = dr_cnt; e0 = err_cnt;
        hold(1'b0, 213);
        irda = 1'b1;
        repeat (3) @(negedge clk);
        check("short_err_pulse", 32'(err), 32'h1);
        check("short_busy", 32'(busy), 32'h0);
        send_frame(8'h01, 8'hFE, 8'h01);
        repeat (10) @(negedge clk);
        check("short_err_count", 32'(err_cnt - e0), 32'h1);
        check("f2_dr_count", 32'(dr_cnt - d0), 32'h1);
        check("f2_addr", 32'(address), 32'h01);
        check("f2_cmd", 32'(command), 32'hFE);

        // Line held low: leader timeout at count LEAD_MARK_MAX+1
        d0 = dr_cnt; e0 = err_cnt;
        irda = 1'b0;
        err_at = 0;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clk);
            if (err) begin
                err_at = i;
                break;
            end
        end
        check("low_err_time", 32'(err_at), 32'd361);
        check("low_busy", 32'(busy), 32'h0);
        repeat (350) @(negedge clk);
        irda = 1'b1;
        repeat (20) @(negedge clk);
        check("low_err_count", 32'(err_cnt - e0), 32'h1);
        check("low_dr_count", 32'(dr_cnt - d0), 32'h0);

        // Reset during bit 10
        d0 = dr_cnt; e0 = err_cnt;
        send_leader();
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        hold(1'b0, 5);
        check("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_addr", 32'(address), 32'h0);
        check("mid_rst_cmd", 32'(command), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        irda = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_err_count", 32'(err_cnt - e0), 32'h0);
        send_frame(8'hA5, 8'h0F, 8'hF0);
        repeat (10) @(negedge clk);
        check("f3_dr_count", 32'(dr_cnt - d0), 32'h1);
        check("f3_addr", 32'(address), 32'hA5);
        check("f3_cmd", 32'(command), 32'h0F);

        // Repeat code after a valid frame
        d0 = dr_cnt; e0 = err_cnt; r0 = rep_cnt;
        hold(1'b0, 320);
        hold(1'b1, 80);
        send_stop();
        repeat (10) @(negedge clk);
`ifdef REPEAT_CODE_EN
        check("rep_count", 32'(rep_cnt - r0), 32'h1);
        check("rep_err_count", 32'(err_cnt - e0), 32'h0);
`else
        check("rep_count", 32'(rep_cnt - r0), 32'h0);
        check("rep_err_count", 32'(err_cnt - e0), 32'h1);
`endif
        check("rep_dr_count", 32'(dr_cnt - d0), 32'h0);
        check("rep_addr", 32'(address), 32'hA5);
        check("rep_cmd", 32'(command), 32'h0F);
        check("rep_busy", 32'(busy), 32'h0);

        check("pulse_exclusive", 32'(excl_cnt), 32'h0);
        check("dr_with_busy", 32'(dr_busy_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
